shake_din_packer: RTL and testbench

SHAKE_DIN_PACKER -- requirements
Module: shake_din_packer

---
 rtl/shake_din_packer.sv | 130 +++++++++++++
 tb/tb_shake_din_packer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/shake_din_packer.sv
// Byte-to-word packer in front of a SHAKE core: gathers message bytes MSB-first
// into 64-bit words and flags the final (possibly partial or empty) word.
module shake_din_packer (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        empty_i,
    input  logic [7:0]  in_byte_i,
    input  logic        in_valid_i,
    input  logic        in_last_i,
    output logic        in_ready_o,
    output logic        start_o,
    output logic [63:0] din_o,
    output logic        din_valid_o,
    output logic        last_din_o,
    output logic [3:0]  last_din_byte_o,
    input  logic        din_ready_i,
    output logic        busy_o
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        FILL      = 3'd2,
        SEND      = 3'd3,
        SEND_LAST = 3'd4
    } state_t;

    state_t     state;
    logic       empty_q;
    logic [3:0] cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state           <= IDLE;
            empty_q         <= 1'b0;
            cnt             <= 4'd0;
            in_ready_o      <= 1'b0;
            start_o         <= 1'b0;
            din_o           <= 64'd0;
            din_valid_o     <= 1'b0;
            last_din_o      <= 1'b0;
            last_din_byte_o <= 4'd0;
            busy_o          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        state   <= START;
                        empty_q <= empty_i;
                        cnt     <= 4'd0;
                        din_o   <= 64'd0;
                        start_o <= 1'b1;
                        busy_o  <= 1'b1;
                    end
                end

                START: begin
                    start_o <= 1'b0;
                    if (empty_q) begin
                        // Zero-byte message: one all-zero final word with no valid bytes.
                        state           <= SEND_LAST;
                        din_o           <= 64'd0;
                        din_valid_o     <= 1'b1;
                        last_din_o      <= 1'b1;
                        last_din_byte_o <= 4'd0;
                    end else begin
                        state      <= FILL;
                        in_ready_o <= 1'b1;
                    end
                end

                FILL: begin
                    if (in_valid_i) begin
                        for (int k = 0; k < 8; k++) begin
                            if (cnt == 4'(k)) begin
                                din_o[63-8*k -: 8] <= in_byte_i;
                            end
                        end
                        cnt <= cnt + 4'd1;
                        if (in_last_i) begin
                            state           <= SEND_LAST;
                            in_ready_o      <= 1'b0;
                            din_valid_o     <= 1'b1;
                            last_din_o      <= 1'b1;
                            last_din_byte_o <= cnt + 4'd1;
                        end else if (cnt == 4'd7) begin
                            state       <= SEND;
                            in_ready_o  <= 1'b0;
                            din_valid_o <= 1'b1;
                        end
                    end
                end

                SEND: begin
                    if (din_ready_i) begin
                        state       <= FILL;
                        din_o       <= 64'd0;
                        cnt         <= 4'd0;
                        din_valid_o <= 1'b0;
                        in_ready_o  <= 1'b1;
                    end
                end

                SEND_LAST: begin
                    if (din_ready_i) begin
                        state           <= IDLE;
                        din_o           <= 64'd0;
                        cnt             <= 4'd0;
                        din_valid_o     <= 1'b0;
                        last_din_o      <= 1'b0;
                        last_din_byte_o <= 4'd0;
                        busy_o          <= 1'b0;
                    end
                end

                default: begin
                    state           <= IDLE;
                    in_ready_o      <= 1'b0;
                    start_o         <= 1'b0;
                    din_valid_o     <= 1'b0;
                    last_din_o      <= 1'b0;
                    last_din_byte_o <= 4'd0;
                    busy_o          <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shake_din_packer.sv
// Randomized bench for shake_din_packer: each message's expected word stream is
// derived from its byte list and compared with the words the DUT hands over.
module tb_shake_din_packer;

    typedef logic [7:0] bq_t[$];

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic        empty_i;
    logic [7:0]  in_byte_i;
    logic        in_valid_i;
    logic        in_last_i;
    logic        in_ready_o;
    logic        start_o;
    logic [63:0] din_o;
    logic        din_valid_o;
    logic        last_din_o;
    logic [3:0]  last_din_byte_o;
    logic        din_ready_i;
    logic        busy_o;

    int total = 0;
    int bad   = 0;

    logic [63:0] got_w[$];
    logic        got_l[$];
    logic [3:0]  got_n[$];

    shake_din_packer dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .start_i         (start_i),
        .empty_i         (empty_i),
        .in_byte_i       (in_byte_i),
        .in_valid_i      (in_valid_i),
        .in_last_i       (in_last_i),
        .in_ready_o      (in_ready_o),
        .start_o         (start_o),
        .din_o           (din_o),
        .din_valid_o     (din_valid_o),
        .last_din_o      (last_din_o),
        .last_din_byte_o (last_din_byte_o),
        .din_ready_i     (din_ready_i),
        .busy_o          (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        start_i     = 1'b0;
        empty_i     = 1'b0;
        in_byte_i   = 8'h00;
        in_valid_i  = 1'b0;
        in_last_i   = 1'b0;
        din_ready_i = 1'b0;
    endtask

    // Sends one message, collects every handed-over word, then compares the
    // collected stream with the word list computed from the bytes.
    task automatic run_msg(input bq_t msg, input bit empty, input int vld_pct,
                           input int rdy_pct, input bit noise_start, input string name);
        int          len;
        int          idx;
        int          cyc;
        bit          done;
        bit          held;
        logic [63:0] held_w;
        int          nexp;
        logic [63:0] exp_w[$];
        logic        exp_l[$];
        logic [3:0]  exp_n[$];
        logic [63:0] w;

        len = empty ? 0 : msg.size();
        if (len == 0) begin
            exp_w.push_back(64'd0); exp_l.push_back(1'b1); exp_n.push_back(4'd0);
        end else begin
            nexp = (len + 7) / 8;
            for (int i = 0; i < nexp; i++) begin
                w = 64'd0;
                for (int j = 0; j < 8; j++)
                    if (8*i + j < len) w[63-8*j -: 8] = msg[8*i + j];
                exp_w.push_back(w);
                exp_l.push_back(i == nexp - 1);
                exp_n.push_back((i == nexp - 1) ? 4'(len - 8*i) : 4'd0);
            end
        end

        got_w.delete(); got_l.delete(); got_n.delete();
        @(negedge clk_i);
        start_i = 1'b1; empty_i = empty;
        @(negedge clk_i);
        start_i = 1'b0; empty_i = 1'b0;
        chk({name, ".start_o"}, 64'(start_o), 64'd1);
        chk({name, ".busy"}, 64'(busy_o), 64'd1);

        idx = 0; cyc = 0; done = 0; held = 0; held_w = 64'd0;
        while (!done && cyc < 4000) begin
            if (cyc > 0) chk({name, ".start_pulse"}, 64'(start_o), 64'd0);
            chk({name, ".rdy_and_vld"}, 64'(in_ready_o & din_valid_o), 64'd0);
            if (held) begin
                chk({name, ".hold_vld"}, 64'(din_valid_o), 64'd1);
                chk({name, ".hold_word"}, din_o, held_w);
            end
            in_valid_i  = (idx < len) && ($urandom_range(99) < vld_pct);
            in_byte_i   = in_valid_i ? msg[idx] : 8'($urandom);
            in_last_i   = in_valid_i ? (idx == len - 1) : 1'($urandom);
            din_ready_i = ($urandom_range(99) < rdy_pct);
            start_i     = noise_start && ($urandom_range(3) == 0);
            empty_i     = 1'($urandom);
            if (in_valid_i && in_ready_o) idx++;
            held = 0;
            if (din_valid_o && din_ready_i) begin
                got_w.push_back(din_o); got_l.push_back(last_din_o); got_n.push_back(last_din_byte_o);
                if (last_din_o) done = 1;
            end else if (din_valid_o) begin
                held = 1; held_w = din_o;
            end
            @(negedge clk_i);
            cyc++;
        end
        if (!done) chk({name, ".timeout"}, 64'd1, 64'd0);
        idle_inputs();
        chk({name, ".idle_busy"}, 64'(busy_o), 64'd0);
        chk({name, ".idle_vld"}, 64'(din_valid_o), 64'd0);
        chk({name, ".bytes_used"}, 64'(idx), 64'(len));
        chk({name, ".nwords"}, 64'(got_w.size()), 64'(exp_w.size()));
        for (int i = 0; i < exp_w.size() && i < got_w.size(); i++) begin
            chk($sformatf("%s.word%0d", name, i), got_w[i], exp_w[i]);
            chk($sformatf("%s.last%0d", name, i), 64'(got_l[i]), 64'(exp_l[i]));
            if (exp_l[i]) chk($sformatf("%s.nbytes%0d", name, i), 64'(got_n[i]), 64'(exp_n[i]));
        end
    endtask

    initial begin
        bq_t   msg;
        string s;
        int    n;

        idle_inputs();
        rst_i = 1'b1;
        #1;
        chk("rst.in_ready", 64'(in_ready_o), 64'd0);
        chk("rst.start_o", 64'(start_o), 64'd0);
        chk("rst.din", din_o, 64'd0);
        chk("rst.din_valid", 64'(din_valid_o), 64'd0);
        chk("rst.last", 64'(last_din_o), 64'd0);
        chk("rst.last_byte", 64'(last_din_byte_o), 64'd0);
        chk("rst.busy", 64'(busy_o), 64'd0);
        @(negedge clk_i); @(negedge clk_i);
        rst_i = 1'b0;

        // Bytes offered while idle must not start anything.
        for (int i = 0; i < 4; i++) begin
            in_valid_i = 1'b1; in_byte_i = 8'hA5; in_last_i = 1'b1; din_ready_i = 1'b1;
            @(negedge clk_i);
            chk("idle_in.busy", 64'(busy_o), 64'd0);
            chk("idle_in.ready", 64'(in_ready_o), 64'd0);
            chk("idle_in.din", din_o, 64'd0);
        end
        idle_inputs();

        msg.delete();
        run_msg(msg, 1'b1, 100, 100, 1'b0, "empty");

        msg.delete();
        for (int i = 0; i < 16; i++) msg.push_back(8'(i));
        run_msg(msg, 1'b0, 100, 100, 1'b0, "x16");
        if (got_w.size() >= 2) begin
            chk("x16.w0_const", got_w[0], 64'h0001020304050607);
            chk("x16.w1_const", got_w[1], 64'h08090A0B0C0D0E0F);
            chk("x16.n1_const", 64'(got_n[1]), 64'd8);
        end else chk("x16.short", 64'(got_w.size()), 64'd2);

        msg.delete();
        for (int b = 1; b <= 2; b++)
            for (int d = 1; d <= 17; d++) begin
                s = $sformatf("blk%0d_d%02d", b, d);
                for (int i = 0; i < 8; i++) msg.push_back(s[i]);
            end
        s = "blk3_d01blk3_";
        for (int i = 0; i < s.len(); i++) msg.push_back(s[i]);
        run_msg(msg, 1'b0, 70, 100, 1'b0, "blk");
        if (got_w.size() > 0) begin
            chk("blk.first_const", got_w[0], 64'h626c6b315f643031);
            chk("blk.last_const", got_w[got_w.size()-1], 64'h626c6b335f000000);
            chk("blk.last_n_const", 64'(got_n[got_n.size()-1]), 64'd5);
        end else chk("blk.none", 64'd0, 64'd1);

        for (int t = 0; t < 12; t++) begin
            msg.delete();
            n = (t < 4) ? 7 + t : 1 + $urandom_range(40);
            for (int i = 0; i < n; i++) msg.push_back(8'($urandom));
            run_msg(msg, 1'b0, 50, 50, t[0], $sformatf("rnd%0d", t));
        end

        // Reset in the middle of a message, then a fresh short message.
        @(negedge clk_i);
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        @(negedge clk_i);
        for (int i = 0; i < 5; i++) begin
            in_valid_i = 1'b1; in_byte_i = 8'h30 + 8'(i); in_last_i = 1'b0;
            @(negedge clk_i);
        end
        idle_inputs();
        #2 rst_i = 1'b1;
        #1;
        chk("midrst.busy", 64'(busy_o), 64'd0);
        chk("midrst.in_ready", 64'(in_ready_o), 64'd0);
        chk("midrst.din", din_o, 64'd0);
        chk("midrst.din_valid", 64'(din_valid_o), 64'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("midrst.stays_idle", 64'(busy_o), 64'd0);
        msg.delete();
        msg.push_back(8'h61); msg.push_back(8'h62); msg.push_back(8'h63);
        run_msg(msg, 1'b0, 100, 100, 1'b0, "abc");
        if (got_w.size() > 0) begin
            chk("abc.const", got_w[0], 64'h6162630000000000);
            chk("abc.n_const", 64'(got_n[0]), 64'd3);
        end else chk("abc.none", 64'd0, 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
